// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, coordinate/velocity widths, sprite size
// and the default movement divider used by the sprite engines.
package game_pkg;

  localparam int SCREEN_W_DEF   = 640;
  localparam int SCREEN_H_DEF   = 480;
  localparam int X_W_DEF        = 10;
  localparam int Y_W_DEF        = 10;
  localparam int D_W_DEF        = 4;
  localparam int SPRITE_W_DEF   = 8;
  localparam int SPRITE_H_DEF   = 8;
  localparam int UPDATE_DIV_DEF = 1000000;

endpackage

// File: rtl/game_step_divider.sv
// Enable-cleared modulo-UPDATE_DIV counter; step is high for the one cycle in
// which the counter sits on its last value while enabled.
module game_step_divider
  import game_pkg::*;
#(
  parameter int UPDATE_DIV = UPDATE_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic step
);

  localparam int CNT_W = $clog2(UPDATE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UPDATE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign step = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || !enable || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_sprite_motion.sv
// Sprite position/velocity engine with on-screen flag and pixel-hit output.
// Define GAME_SPRITE_PIXEL_PIPE_EN to register pixel_hit (1-cycle latency).
module game_sprite_motion
  import game_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int X_W        = X_W_DEF,
  parameter int Y_W        = Y_W_DEF,
  parameter int SPRITE_W   = SPRITE_W_DEF,
  parameter int SPRITE_H   = SPRITE_H_DEF,
  parameter int D_W        = D_W_DEF,
  parameter int UPDATE_DIV = UPDATE_DIV_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           write_xy,
  input  logic [X_W-1:0] write_x,
  input  logic [Y_W-1:0] write_y,
  input  logic           write_dxy,
  input  logic [D_W-1:0] write_dx,
  input  logic [D_W-1:0] write_dy,
  input  logic           enable_update,
  input  logic [X_W-1:0] pixel_x,
  input  logic [Y_W-1:0] pixel_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           within_screen,
  output logic           pixel_hit
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - SPRITE_W);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - SPRITE_H);

  logic signed [D_W-1:0] dx, dy;
  logic                  step;
  logic [X_W:0]          x_end;
  logic [Y_W:0]          y_end;
  logic                  hit;

  function automatic logic [X_W-1:0] sext_x(input logic signed [D_W-1:0] d);
    return X_W'(d);
  endfunction

  function automatic logic [Y_W-1:0] sext_y(input logic signed [D_W-1:0] d);
    return Y_W'(d);
  endfunction

  // A position load restarts the divider so the next step is a full period away.
  game_step_divider #(
    .UPDATE_DIV(UPDATE_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (enable_update),
    .restart(write_xy),
    .step   (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x  <= '0;
      y  <= '0;
      dx <= '0;
      dy <= '0;
    end else begin
      if (write_xy) begin
        x <= write_x;
        y <= write_y;
      end else if (step) begin
        x <= x + sext_x(dx);
        y <= y + sext_y(dy);
      end
      if (write_dxy) begin
        dx <= write_dx;
        dy <= write_dy;
      end
    end
  end

  assign within_screen = (x <= X_MAX) && (y <= Y_MAX);

  // One extra bit keeps the right/bottom edge from wrapping near the top of range.
  assign x_end = {1'b0, x} + (X_W+1)'(SPRITE_W);
  assign y_end = {1'b0, y} + (Y_W+1)'(SPRITE_H);
  assign hit   = (pixel_x >= x) && ({1'b0, pixel_x} < x_end) &&
                 (pixel_y >= y) && ({1'b0, pixel_y} < y_end);

`ifdef GAME_SPRITE_PIXEL_PIPE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_hit <= 1'b0;
    end else begin
      pixel_hit <= hit;
    end
  end
`else
  assign pixel_hit = hit;
`endif

endmodule

// File: tb/tb_game_sprite_motion.sv
// Scoreboard bench for game_sprite_motion with UPDATE_DIV=4; also covers the
// registered pixel_hit build when GAME_SPRITE_PIXEL_PIPE_EN is defined.
module tb_game_sprite_motion;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_xy, write_dxy, enable_update;
  logic [9:0] write_x, write_y, pixel_x, pixel_y;
  logic [3:0] write_dx, write_dy;
  logic [9:0] x, y;
  logic       within_screen, pixel_hit;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       ws;
  } pos_t;

  pos_t pq[$];
  logic hq[$];
  int   checks = 0;
  int   errors = 0;

  game_sprite_motion #(
    .SCREEN_W(640), .SCREEN_H(480), .X_W(10), .Y_W(10),
    .SPRITE_W(8), .SPRITE_H(8), .D_W(4), .UPDATE_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset),
    .write_xy(write_xy), .write_x(write_x), .write_y(write_y),
    .write_dxy(write_dxy), .write_dx(write_dx), .write_dy(write_dy),
    .enable_update(enable_update),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .x(x), .y(y), .within_screen(within_screen), .pixel_hit(pixel_hit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pos(input int ex, input int ey, input bit ews);
    pos_t p;
    p.x  = ex[9:0];
    p.y  = ey[9:0];
    p.ws = ews;
    pq.push_back(p);
  endtask

  task automatic load(input int px, input int py, input int pdx, input int pdy);
    write_xy  = 1'b1;
    write_dxy = 1'b1;
    write_x   = px[9:0];
    write_y   = py[9:0];
    write_dx  = pdx[3:0];
    write_dy  = pdy[3:0];
    tick();
    write_xy  = 1'b0;
    write_dxy = 1'b0;
  endtask

  task automatic test_reset;
    pos_t p;
    logic hexp;
    reset = 1'b1;
    write_xy = 0; write_dxy = 0; enable_update = 0;
    write_x = 0; write_y = 0; write_dx = 0; write_dy = 0;
    pixel_x = 0; pixel_y = 0;
    tick(2);
    expect_pos(0, 0, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL reset_state got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
`ifdef GAME_SPRITE_PIXEL_PIPE_EN
    hexp = 1'b0;
`else
    hexp = 1'b1;
`endif
    checks++;
    if (pixel_hit !== hexp) begin
      errors++;
      $display("FAIL reset_pixel_hit got %0b want %0b", pixel_hit, hexp);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_motion;
    pos_t p;
    load(100, 200, 2, -1);
    expect_pos(100, 200, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL motion_load got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
    enable_update = 1'b1;
    tick(3);
    expect_pos(100, 200, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL motion_early got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    tick();
    expect_pos(102, 199, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL motion_step1 got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
    tick(4);
    expect_pos(104, 198, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL motion_step2 got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
  endtask

  task automatic test_enable_gap;
    pos_t p;
    tick(3);
    enable_update = 1'b0;
    tick();
    enable_update = 1'b1;
    tick(3);
    expect_pos(104, 198, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL gap_no_step got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    tick();
    expect_pos(106, 197, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL gap_step got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    enable_update = 1'b0;
  endtask

  task automatic test_edges;
    pos_t p;
    load(1, 10, -2, 0);
    enable_update = 1'b1;
    tick(4);
    expect_pos(1023, 10, 0);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL left_wrap got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
    enable_update = 1'b0;
    load(632, 10, 1, 0);
    expect_pos(632, 10, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL right_in got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
    enable_update = 1'b1;
    tick(4);
    expect_pos(633, 10, 0);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL right_out got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
    enable_update = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load(0, 472 + i, 0, 0);
      expect_pos(0, 472 + i, (i == 0));
      p = pq.pop_front();
      checks++;
      if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
        errors++;
        $display("FAIL bottom_edge got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
      end
    end
  endtask

  task automatic test_write_during_step;
    pos_t p;
    load(10, 20, 1, 1);
    enable_update = 1'b1;
    tick(3);
    write_xy = 1'b1; write_x = 10'd300; write_y = 10'd400;
    tick();
    write_xy = 1'b0;
    expect_pos(300, 400, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL xy_over_step got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    tick(3);
    expect_pos(300, 400, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL xy_restart_hold got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    tick();
    expect_pos(301, 401, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL xy_restart_step got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    tick(3);
    write_dxy = 1'b1; write_dx = 4'hD; write_dy = 4'h2;
    tick();
    write_dxy = 1'b0;
    expect_pos(302, 402, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL dxy_old_used got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    tick(4);
    expect_pos(299, 404, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL dxy_new_used got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    enable_update = 1'b0;
  endtask

  task automatic test_reset_mid_step;
    pos_t p;
    load(200, 100, 1, 1);
    enable_update = 1'b1;
    tick(3);
    #2 reset = 1'b1;
    #1;
    expect_pos(0, 0, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y, within_screen} !== {p.x, p.y, p.ws}) begin
      errors++;
      $display("FAIL reset_mid got x=%0d y=%0d ws=%0b want x=%0d y=%0d ws=%0b", x, y, within_screen, p.x, p.y, p.ws);
    end
    tick();
    reset = 1'b0;
    tick(4);
    expect_pos(0, 0, 1);
    p = pq.pop_front();
    checks++;
    if ({x, y} !== {p.x, p.y}) begin
      errors++;
      $display("FAIL reset_clears_dxy got x=%0d y=%0d want x=%0d y=%0d", x, y, p.x, p.y);
    end
    enable_update = 1'b0;
  endtask

  task automatic test_back_to_back;
    int  tx[6] = '{50, 57, 58, 49, 57, 50};
    int  ty[6] = '{60, 67, 60, 60, 68, 59};
    bit  th[6] = '{1, 1, 0, 0, 0, 0};
    int  px, py;
    logic e, got;
    load(50, 60, 0, 0);
    for (int i = 0; i < 22; i++) begin
      if (i < 6) begin
        px = tx[i]; py = ty[i]; e = th[i];
      end else begin
        px = 44 + $urandom_range(0, 20);
        py = 54 + $urandom_range(0, 20);
        e  = (px >= 50) && (px < 58) && (py >= 60) && (py < 68);
      end
      pixel_x = px[9:0];
      pixel_y = py[9:0];
      hq.push_back(e);
`ifdef GAME_SPRITE_PIXEL_PIPE_EN
      tick();
`else
      #1;
`endif
      e = hq.pop_front();
      got = pixel_hit;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pixel_hit px=%0d py=%0d got %0b want %0b", px, py, got, e);
      end
`ifndef GAME_SPRITE_PIXEL_PIPE_EN
      tick();
`endif
    end
  endtask

  initial begin
    test_reset();
    test_motion();
    test_enable_gap();
    test_edges();
    test_write_during_step();
    test_reset_mid_step();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sprite_motion.md
# game_sprite_motion

Per-sprite position/velocity engine sitting directly downstream of the game master FSM: it consumes the FSM's write_xy / write_dxy / enable_update strobes, moves the sprite at a fixed divided rate, reports sprite_within_screen back to the FSM, and produces a pixel-hit signal for the display mixer. One instance is used for the target and one for the torpedo.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- X_W, 10, width of x and pixel_x
- Y_W, 10, width of y and pixel_y
- SPRITE_W, 8, sprite width in pixels
- SPRITE_H, 8, sprite height in pixels
- D_W, 4, width of signed two's-complement dx/dy
- UPDATE_DIV, 1000000, clk cycles per movement step, ≥ 2
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- write_xy  in  1  load x/y from write_x/write_y
- write_x  in  X_W  start x
- write_y  in  Y_W  start y
- write_dxy  in  1  load dx/dy from write_dx/write_dy
- write_dx  in  D_W  signed x velocity per step
- write_dy  in  D_W  signed y velocity per step
- enable_update  in  1  level; allows movement steps
- pixel_x  in  X_W  current display column
- pixel_y  in  Y_W  current display row
- x  out  X_W  current sprite left edge
- y  out  Y_W  current sprite top edge
- within_screen  out  1  sprite fully on screen
- pixel_hit  out  1  (pixel_x, pixel_y) lies inside sprite

## Operation
- Registers: x, y (unsigned), dx, dy (signed), step counter cnt (clog2(UPDATE_DIV) bits).
- Reset: x=0, y=0, dx=0, dy=0, cnt=0; hence within_screen=1, pixel_hit as per Timing.
- write_xy: x<=write_x, y<=write_y; cnt<=0.
- write_dxy: dx<=write_dx, dy<=write_dy; independent of write_xy, both may fire in one cycle.
- Step counter: while enable_update=0, cnt<=0. While 1, cnt increments; at cnt==UPDATE_DIV-1 cnt<=0 and a step occurs.
- Step: x<=x+sext(dx), y<=y+sext(dy), modulo 2^X_W / 2^Y_W (free wrap, no saturation).
- Priority: write_xy overrides a same-cycle step (step discarded, cnt<=0). write_dxy same cycle as a step: step uses old dx/dy.
- within_screen = (x <= SCREEN_W-SPRITE_W) && (y <= SCREEN_H-SPRITE_H), unsigned compare; leftward/upward wrap past 0 yields large value, hence off-screen.
- pixel_hit = pixel_x ≥ x && pixel_x < x+SPRITE_W && pixel_y ≥ y && pixel_y < y+SPRITE_H, sums computed one bit wider than operands (no wrap).

## Timing
- x, y, dx, dy visible the cycle after the write strobe.
- within_screen combinational from registered x/y: valid the cycle after a write or step; never glitches within a cycle from inputs.
- First step after enable_update rises: UPDATE_DIV cycles later; then every UPDATE_DIV cycles.
- pixel_hit: combinational from pixel_x/pixel_y by default (0-cycle latency).
- Reset asserted mid-step: all registers return to reset values immediately; no partial step.

## Configuration
- GAME_SPRITE_PIXEL_PIPE_EN defined: pixel_hit registered, 1-cycle latency relative to pixel_x/pixel_y, reset value 0; mixer must delay its coordinates by one cycle.
- Undefined: pixel_hit purely combinational as above.

## Structure
- Shared package game_pkg: SCREEN_W/SCREEN_H defaults, X_W/Y_W, D_W, sprite size constants.
- One sub-module: game_step_divider (enable-cleared modulo-UPDATE_DIV counter emitting a one-cycle step pulse).

## Test plan
- Reset, then write_xy x=100 y=200, write_dxy dx=+2 dy=-1, enable_update=1, UPDATE_DIV=4 -> x,y = 102,199 after 4 cycles, 104,198 after 8.
- Hold enable_update 3 cycles, drop 1 cycle, raise again -> no step until 4 full enabled cycles after re-raise.
- x=1, dx=-2, one step -> x=1023, within_screen=0 the next cycle.
- x=632, SPRITE_W=8 -> within_screen=1; step dx=+1 -> x=633, within_screen=0.
- write_xy in the same cycle as a step -> x/y equal written values, counter restarts, next step UPDATE_DIV cycles later.
- Sprite at (50,60): pixel (50,60) and (57,67) -> hit=1; (58,60) and (49,60) -> 0; with GAME_SPRITE_PIXEL_PIPE_EN same results one cycle later.
